// File: rtl/ex_stage.sv
// Execute stage: ALU, destination select and EX/MEM register.
// MUL runs as an iterative shift-add over 32/MUL_RADIX_BITS cycles and stalls the front end meanwhile.
module ex_stage #(
    parameter int unsigned MUL_RADIX_BITS = 1
) (
    input  logic        reloj,
    input  logic        resetEX,
    input  logic [2:0]  ALU_FUN,
    input  logic        SEL_ALU,
    input  logic        SEL_REG,
    input  logic [2:0]  ctrl_MEM_exe,
    input  logic [1:0]  ctrl_WB_exe,
    input  logic [31:0] A,
    input  logic [31:0] DOB_exe,
    input  logic [31:0] imm_ext_exe,
    input  logic [4:0]  rt_exe,
    input  logic [4:0]  rd_exe,
    output logic [31:0] ALU_out_mem,
    output logic [31:0] DOB_mem,
    output logic [4:0]  wr_reg_mem,
    output logic        zero_mem,
    output logic [2:0]  ctrl_MEM_mem,
    output logic [1:0]  ctrl_WB_mem,
    output logic        stall_ex
);

    localparam int unsigned N_ITER = 32 / MUL_RADIX_BITS;
    localparam int unsigned CntW   = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N_ITER - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpNor = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpSll = 3'b111;

    typedef enum logic [0:0] {StIdle, StMulRun} state_e;

    state_e state_q, state_d;

    logic [31:0]     mcand_q, mcand_d;
    logic [31:0]     mplier_q, mplier_d;
    logic [31:0]     acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Shadow copies of the MUL instruction's pass-through fields
    logic [31:0] sh_dob_q, sh_dob_d;
    logic [4:0]  sh_wr_q, sh_wr_d;
    logic [2:0]  sh_mem_q, sh_mem_d;
    logic [1:0]  sh_wb_q, sh_wb_d;

    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] dob_q, dob_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic        zero_q, zero_d;
    logic [2:0]  ctrl_mem_q, ctrl_mem_d;
    logic [1:0]  ctrl_wb_q, ctrl_wb_d;

    logic [31:0] b_op;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] pp;
    logic [31:0] acc_sum;
    logic        stall;

    always_comb begin
        b_op = SEL_ALU ? imm_ext_exe : DOB_exe;
        dest = SEL_REG ? rd_exe : rt_exe;
    end

    always_comb begin
        alu_res = '0;
        case (ALU_FUN)
            OpAdd:   alu_res = A + b_op;
            OpSub:   alu_res = A - b_op;
            OpAnd:   alu_res = A & b_op;
            OpOr:    alu_res = A | b_op;
            OpSlt:   alu_res = {31'd0, $signed(A) < $signed(b_op)};
            OpNor:   alu_res = ~(A | b_op);
            OpMul:   alu_res = '0;
            OpSll:   alu_res = A << b_op[4:0];
            default: alu_res = '0;
        endcase
    end

    // Partial product: multiplicand times the low MUL_RADIX_BITS multiplier bits
    always_comb begin
        pp = '0;
        for (int i = 0; i < int'(MUL_RADIX_BITS); i++) begin
            if (mplier_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
        acc_sum = acc_q + pp;
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sh_dob_d   = sh_dob_q;
        sh_wr_d    = sh_wr_q;
        sh_mem_d   = sh_mem_q;
        sh_wb_d    = sh_wb_q;
        alu_out_d  = '0;
        dob_d      = '0;
        wr_reg_d   = '0;
        zero_d     = 1'b0;
        ctrl_mem_d = '0;
        ctrl_wb_d  = '0;
        stall      = 1'b0;

        case (state_q)
            StIdle: begin
                if (ALU_FUN == OpMul) begin
                    stall    = 1'b1;
                    mcand_d  = A;
                    mplier_d = b_op;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sh_dob_d = DOB_exe;
                    sh_wr_d  = dest;
                    sh_mem_d = ctrl_MEM_exe;
                    sh_wb_d  = ctrl_WB_exe;
                    state_d  = StMulRun;
                end else begin
                    alu_out_d  = alu_res;
                    dob_d      = DOB_exe;
                    wr_reg_d   = dest;
                    zero_d     = (alu_res == 32'd0);
                    ctrl_mem_d = ctrl_MEM_exe;
                    ctrl_wb_d  = ctrl_WB_exe;
                end
            end
            StMulRun: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << MUL_RADIX_BITS;
                mplier_d = mplier_q >> MUL_RADIX_BITS;
                cnt_d    = cnt_q + 1'b1;
                // Stall drops here so upstream advances on the product's edge
                if (cnt_q == CntLast) begin
                    alu_out_d  = acc_sum;
                    dob_d      = sh_dob_q;
                    wr_reg_d   = sh_wr_q;
                    zero_d     = (acc_sum == 32'd0);
                    ctrl_mem_d = sh_mem_q;
                    ctrl_wb_d  = sh_wb_q;
                    state_d    = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (resetEX) begin
            state_q    <= StIdle;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sh_dob_q   <= '0;
            sh_wr_q    <= '0;
            sh_mem_q   <= '0;
            sh_wb_q    <= '0;
            alu_out_q  <= '0;
            dob_q      <= '0;
            wr_reg_q   <= '0;
            zero_q     <= 1'b0;
            ctrl_mem_q <= '0;
            ctrl_wb_q  <= '0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sh_dob_q   <= sh_dob_d;
            sh_wr_q    <= sh_wr_d;
            sh_mem_q   <= sh_mem_d;
            sh_wb_q    <= sh_wb_d;
            alu_out_q  <= alu_out_d;
            dob_q      <= dob_d;
            wr_reg_q   <= wr_reg_d;
            zero_q     <= zero_d;
            ctrl_mem_q <= ctrl_mem_d;
            ctrl_wb_q  <= ctrl_wb_d;
        end
    end

    assign ALU_out_mem  = alu_out_q;
    assign DOB_mem      = dob_q;
    assign wr_reg_mem   = wr_reg_q;
    assign zero_mem     = zero_q;
    assign ctrl_MEM_mem = ctrl_mem_q;
    assign ctrl_WB_mem  = ctrl_wb_q;
    assign stall_ex     = stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, radix-1 and radix-4 multiply, reset abort, back-to-back MULs.
module tb_ex_stage;

    logic        reloj;
    logic        resetEX;
    logic [2:0]  ALU_FUN;
    logic [2:0]  fun4;
    logic        SEL_ALU;
    logic        SEL_REG;
    logic [2:0]  ctrl_MEM_exe;
    logic [1:0]  ctrl_WB_exe;
    logic [31:0] A;
    logic [31:0] DOB_exe;
    logic [31:0] imm_ext_exe;
    logic [4:0]  rt_exe;
    logic [4:0]  rd_exe;

    logic [31:0] alu1, dob1, alu4, dob4;
    logic [4:0]  wr1, wr4;
    logic        zero1, zero4, stall1, stall4;
    logic [2:0]  cm1, cm4;
    logic [1:0]  cw1, cw4;

    int n_checks = 0;
    int n_errors = 0;

    ex_stage #(.MUL_RADIX_BITS(1)) dut (
        .reloj(reloj), .resetEX(resetEX), .ALU_FUN(ALU_FUN), .SEL_ALU(SEL_ALU),
        .SEL_REG(SEL_REG), .ctrl_MEM_exe(ctrl_MEM_exe), .ctrl_WB_exe(ctrl_WB_exe), .A(A),
        .DOB_exe(DOB_exe), .imm_ext_exe(imm_ext_exe), .rt_exe(rt_exe), .rd_exe(rd_exe),
        .ALU_out_mem(alu1), .DOB_mem(dob1), .wr_reg_mem(wr1), .zero_mem(zero1),
        .ctrl_MEM_mem(cm1), .ctrl_WB_mem(cw1), .stall_ex(stall1)
    );

    ex_stage #(.MUL_RADIX_BITS(4)) dut4 (
        .reloj(reloj), .resetEX(resetEX), .ALU_FUN(fun4), .SEL_ALU(SEL_ALU),
        .SEL_REG(SEL_REG), .ctrl_MEM_exe(ctrl_MEM_exe), .ctrl_WB_exe(ctrl_WB_exe), .A(A),
        .DOB_exe(DOB_exe), .imm_ext_exe(imm_ext_exe), .rt_exe(rt_exe), .rd_exe(rd_exe),
        .ALU_out_mem(alu4), .DOB_mem(dob4), .wr_reg_mem(wr4), .zero_mem(zero4),
        .ctrl_MEM_mem(cm4), .ctrl_WB_mem(cw4), .stall_ex(stall4)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit s, input logic [31:0] e_alu,
                           input logic [31:0] e_dob, input logic [4:0] e_wr, input logic e_zero,
                           input logic [2:0] e_cm, input logic [1:0] e_cw);
        chk({tag, ".alu"},  s ? alu4 : alu1, e_alu);
        chk({tag, ".dob"},  s ? dob4 : dob1, e_dob);
        chk({tag, ".wr"},   {27'd0, s ? wr4 : wr1}, {27'd0, e_wr});
        chk({tag, ".zero"}, {31'd0, s ? zero4 : zero1}, {31'd0, e_zero});
        chk({tag, ".cmem"}, {29'd0, s ? cm4 : cm1}, {29'd0, e_cm});
        chk({tag, ".cwb"},  {30'd0, s ? cw4 : cw1}, {30'd0, e_cw});
    endtask

    task automatic set_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] dob,
                          input logic [31:0] imm, input logic sel_alu, input logic sel_reg,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [2:0] cm,
                          input logic [1:0] cw);
        ALU_FUN = fun; A = a; DOB_exe = dob; imm_ext_exe = imm; SEL_ALU = sel_alu;
        SEL_REG = sel_reg; rt_exe = rt; rd_exe = rd; ctrl_MEM_exe = cm; ctrl_WB_exe = cw;
    endtask

    // Runs a MUL until the stall drops (last iteration cycle); caller presents the next op.
    task automatic mul_seq(input string tag, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [2:0] cm,
                           input logic [1:0] cw, input int exp_stall);
        int n;
        int bad;
        set_op(s ? 3'b000 : 3'b110, a, b, 32'd0, 1'b0, 1'b1, 5'd0, rd, cm, cw);
        fun4 = s ? 3'b110 : 3'b000;
        #1;
        n = 0;
        bad = 0;
        while ((s ? stall4 : stall1) && n < 100) begin
            n++;
            step();
            if (n == 1) begin
                A = 32'hDEADBEEF; DOB_exe = 32'h13579BDF; imm_ext_exe = 32'h2468;
                SEL_ALU = 1'b1; rd_exe = 5'd31; rt_exe = 5'd30;
                ctrl_MEM_exe = 3'b111; ctrl_WB_exe = 2'b11;
            end
            if (s ? ({alu4, dob4, wr4, zero4, cm4, cw4} != '0)
                  : ({alu1, dob1, wr1, zero1, cm1, cw1} != '0)) bad++;
        end
        chk({tag, ".stall_cycles"}, n, exp_stall);
        chk({tag, ".bubbles"}, bad, 0);
    endtask

    initial begin
        int hits;
        resetEX = 1'b1;
        fun4 = 3'b000;
        set_op(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 2'd0);
        step();
        step();
        chk_out("reset", 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 3'd0, 2'd0);
        chk_out("reset4", 1'b1, 32'd0, 32'd0, 5'd0, 1'b0, 3'd0, 2'd0);
        chk("reset.stall", {31'd0, stall1}, 32'd0);
        resetEX = 1'b0;

        set_op(3'b000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd3, 5'd9, 3'd0, 2'd0);
        #1;
        chk("add.stall", {31'd0, stall1}, 32'd0);
        step();
        chk_out("add", 1'b0, 32'd12, 32'd7, 5'd9, 1'b0, 3'd0, 2'd0);

        set_op(3'b001, 32'd3, 32'd7, 32'd3, 1'b1, 1'b0, 5'd4, 5'd9, 3'b101, 2'b11);
        step();
        chk_out("sub", 1'b0, 32'd0, 32'd7, 5'd4, 1'b1, 3'b101, 2'b11);

        set_op(3'b100, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1, 1'b0, 5'd2, 5'd0, 3'd0, 2'd0);
        step();
        chk("slt", alu1, 32'd1);
        set_op(3'b111, 32'd1, 32'd0, 32'h21, 1'b1, 1'b0, 5'd2, 5'd0, 3'd0, 2'd0);
        step();
        chk("sll", alu1, 32'd2);
        set_op(3'b010, 32'hF0F00000, 32'h0FF000FF, 32'd0, 1'b0, 1'b0, 5'd2, 5'd0, 3'd0, 2'd0);
        step();
        chk("and", alu1, 32'h00F00000);
        ALU_FUN = 3'b011;
        step();
        chk("or", alu1, 32'hFFF000FF);
        ALU_FUN = 3'b101;
        step();
        chk("nor", alu1, 32'h000FFF00);

        mul_seq("mul6x7", 1'b0, 32'd6, 32'd7, 5'd10, 3'b010, 2'b01, 32);
        set_op(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 2'd0);
        step();
        chk_out("mul6x7.res", 1'b0, 32'd42, 32'd7, 5'd10, 1'b0, 3'b010, 2'b01);

        mul_seq("mulneg", 1'b0, 32'hFFFFFFFF, 32'd2, 5'd7, 3'b001, 2'b00, 32);
        set_op(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 2'd0);
        step();
        chk_out("mulneg.res", 1'b0, 32'hFFFFFFFE, 32'd2, 5'd7, 1'b0, 3'b001, 2'b00);

        mul_seq("mulzero", 1'b0, 32'd0, 32'd5, 5'd1, 3'b000, 2'b10, 32);
        set_op(3'b000, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 2'd0);
        step();
        chk_out("mulzero.res", 1'b0, 32'd0, 32'd5, 5'd1, 1'b1, 3'b000, 2'b10);

        // Back-to-back: 3x3, 4x5, then 2+2
        mul_seq("b2b_a", 1'b0, 32'd3, 32'd3, 5'd11, 3'b001, 2'b10, 32);
        set_op(3'b110, 32'd4, 32'd5, 32'd0, 1'b0, 1'b1, 5'd0, 5'd12, 3'b100, 2'b11);
        step();
        chk_out("b2b_a.res", 1'b0, 32'd9, 32'd3, 5'd11, 1'b0, 3'b001, 2'b10);
        mul_seq("b2b_b", 1'b0, 32'd4, 32'd5, 5'd12, 3'b100, 2'b11, 32);
        set_op(3'b000, 32'd2, 32'd2, 32'd0, 1'b0, 1'b1, 5'd0, 5'd13, 3'b000, 2'b10);
        step();
        chk_out("b2b_b.res", 1'b0, 32'd20, 32'd5, 5'd12, 1'b0, 3'b100, 2'b11);
        step();
        chk_out("b2b_c.res", 1'b0, 32'd4, 32'd2, 5'd13, 1'b0, 3'b000, 2'b10);
        chk("b2b_c.stall", {31'd0, stall1}, 32'd0);

        // Reset at cnt = 10 abandons the multiply
        set_op(3'b110, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd10, 3'b010, 2'b01);
        step();
        for (int i = 0; i < 10; i++) step();
        chk("rstmul.stall_before", {31'd0, stall1}, 32'd1);
        resetEX = 1'b1;
        set_op(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd14, 3'b000, 2'b01);
        step();
        chk_out("rstmul.reset", 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 3'd0, 2'd0);
        chk("rstmul.stall", {31'd0, stall1}, 32'd0);
        resetEX = 1'b0;
        step();
        chk_out("rstmul.add", 1'b0, 32'd2, 32'd1, 5'd14, 1'b0, 3'b000, 2'b01);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (alu1 == 32'd42 || stall1) hits++;
        end
        chk("rstmul.no_product", hits, 0);

        // Radix-4 instance
        ALU_FUN = 3'b000;
        mul_seq("r4_6x7", 1'b1, 32'd6, 32'd7, 5'd10, 3'b010, 2'b01, 8);
        fun4 = 3'b000;
        set_op(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 2'd0);
        step();
        chk_out("r4_6x7.res", 1'b1, 32'd42, 32'd7, 5'd10, 1'b0, 3'b010, 2'b01);
        mul_seq("r4_neg", 1'b1, 32'hFFFFFFFF, 32'd2, 5'd7, 3'b001, 2'b00, 8);
        fun4 = 3'b000;
        set_op(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 2'd0);
        step();
        chk_out("r4_neg.res", 1'b1, 32'hFFFFFFFE, 32'd2, 5'd7, 1'b0, 3'b001, 2'b00);
        chk("r4.stall_after", {31'd0, stall4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the ID/EX register outputs and computes the ALU result, including a multi-cycle iterative multiply.
- Selects the destination register.
- Registers the result, the store data and the pass-through control into the EX/MEM boundary.
- Drives stall_ex to the hazard unit while a multiply is in flight.

Parameters:
- MUL_RADIX_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4. N_ITER = 32/MUL_RADIX_BITS.

Ports:
- reloj  in  1  clock; all state updates on the rising edge
- resetEX  in  1  synchronous, active-high reset
- ALU_FUN  in  3  operation code
- SEL_ALU  in  1  1: B = imm_ext_exe; 0: B = DOB_exe
- SEL_REG  in  1  1: destination = rd_exe; 0: destination = rt_exe
- ctrl_MEM_exe  in  3  MEM-stage control, passed through
- ctrl_WB_exe  in  2  WB-stage control, passed through
- A  in  32  operand A
- DOB_exe  in  32  register B value, also the store data
- imm_ext_exe  in  32  sign-extended immediate
- rt_exe  in  5  rt field
- rd_exe  in  5  rd field
- ALU_out_mem  out  32  registered result
- DOB_mem  out  32  registered store data
- wr_reg_mem  out  5  registered destination register
- zero_mem  out  1  registered (result == 0)
- ctrl_MEM_mem  out  3  registered MEM control
- ctrl_WB_mem  out  2  registered WB control
- stall_ex  out  1  combinational; hazard unit freezes PC, IF/ID and ID/EX while high

Behaviour:
- Clock and reset: one clock (reloj); reset resetEX is synchronous, active-high.
  - Reset wins over every other event.
  - All registered outputs go to 0 and the FSM goes to IDLE.
  - After reset, stall_ex = 0 unless ALU_FUN = 110.
- Operand B: B = SEL_ALU ? imm_ext_exe : DOB_exe.
- ALU_FUN codes (all arithmetic 32-bit, overflow wraps, no exception):
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND
  - 011 OR
  - 100 SLT: signed compare, result 1 or 0
  - 101 NOR
  - 110 MUL: low 32 bits of A*B
  - 111 SLL: A << B[4:0]
- Single-cycle ops (not 110): one edge of latency.
  - On the edge, EX/MEM loads the result, DOB_exe, the selected destination register, zero and both control fields.
  - stall_ex = 0.
- FSM states: IDLE, MUL_RUN.
  - IDLE with ALU_FUN = 110:
    - On the edge: latch A into the multiplicand, B into the multiplier, clear the accumulator, cnt = 0.
    - Also latch DOB_exe, the destination register, ctrl_MEM_exe and ctrl_WB_exe into shadow registers.
    - EX/MEM loads a bubble: all outputs 0. Go to MUL_RUN.
  - MUL_RUN, each edge:
    - Add the multiplicand × the low MUL_RADIX_BITS bits of the multiplier into the accumulator.
    - Shift the multiplicand left and the multiplier right by MUL_RADIX_BITS; cnt++.
    - EX/MEM loads a bubble, except on the last iteration.
  - Last iteration (cnt = N_ITER-1):
    - EX/MEM loads the final product, with the shadow DOB, destination register and controls.
    - zero_mem reflects the product. Return to IDLE.
- Inputs are ignored in MUL_RUN; only the latched copies are used.
- stall_ex = (IDLE & ALU_FUN = 110) | (MUL_RUN & cnt != N_ITER-1).
  - It drops in the last iteration cycle, so the upstream stages advance on the same edge that the product is written.
  - With MUL_RADIX_BITS = 1, stall_ex is high for 32 consecutive cycles and the product appears after the 33rd edge.
- Bubble input (all ctrl fields 0): processed like any other op. No special casing; the result is harmless because ctrl_WB_mem and ctrl_MEM_mem are 0.
- Reset mid-MUL_RUN: the multiply is abandoned and no product is ever written. stall_ex = 0 on the following cycle if the input is no longer MUL.
- Back-to-back MULs: after returning to IDLE, the next MUL presented on ID/EX starts a new sequence immediately; there are no idle gap cycles.

Test Plan:
- ADD: A=5, DOB_exe=7, SEL_ALU=0, ALU_FUN=000, rt=3, rd=9, SEL_REG=1 -> after 1 edge ALU_out_mem=12, wr_reg_mem=9, zero_mem=0, stall_ex=0 throughout.
- SUB/zero and controls: A=3, imm=3, SEL_ALU=1, ALU_FUN=001, SEL_REG=0, rt=4, ctrl_MEM=101, ctrl_WB=11 -> ALU_out_mem=0, zero_mem=1, wr_reg_mem=4, ctrl_MEM_mem=101, ctrl_WB_mem=11.
- SLT signed / SLL: A=0xFFFFFFFF, B=1, SLT -> 1. A=1, B=0x21, SLL -> 0x00000002 (only B[4:0] used).
- MUL, radix 1: A=6, B=7 -> stall_ex high exactly 32 cycles, EX/MEM all zero during the stall, 42 after edge 33. A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE. Repeat with MUL_RADIX_BITS=4: stall 8 cycles, same products.
- Reset mid-multiply: MUL 6×7, assert resetEX when cnt=10, then present ADD 1+1 -> all outputs 0 on the reset edge, no 42 ever appears, stall_ex=0, next edge ALU_out_mem=2.
- Back-to-back: MUL 3×3, then MUL 4×5, then ADD 2+2 -> EX/MEM shows 9, then 20, then 4. Controls and destination register match each instruction; no lost or duplicated op.
